lsu_data: RTL

- Load/store unit between the RV32i core and the data memory (dataMem).
- Accepts one byte, halfword or word load/store request at a time from the core over a valid/ready handshake.
- Converts each request into word-aligned memory accesses with a 4-bit byte write mask (write_transfer). Misaligned accesses that cross a word boundary are split into two accesses.
- For loads, returns sign- or zero-extended data to the core with a one-cycle response pulse.

---
 rtl/lsu_pkg.sv | 25 ++
 rtl/lsu_align.sv | 43 ++++
 rtl/lsu_data.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: size encodings, FSM states
// and the access-size helper.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ACC0 = 2'b01,
    ACC1 = 2'b10,
    CAPT = 2'b11
  } state_t;

  // The reserved encoding 2'b11 behaves as a word access.
  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    case (size)
      SZ_BYTE: size_to_bytes = 3'd1;
      SZ_HALF: size_to_bytes = 3'd2;
      default: size_to_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational datapath of the load/store unit: byte-lane mask, lane-shifted
// store data for both words of a split access, and load shift/extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] w0,
  input  logic [31:0] w1,
  output logic [7:0]  mask,
  output logic [31:0] wdata_lo,
  output logic [31:0] wdata_hi,
  output logic [31:0] rdata
);

  logic [4:0]  shamt;
  logic [3:0]  base;
  logic [63:0] wide_w;
  logic [31:0] raw;

  assign shamt = {offset, 3'b000};
  assign base  = 4'((5'd1 << size_to_bytes(size)) - 5'd1);
  assign mask  = {4'b0000, base} << offset;

  // The upper half of the shifted store data is exactly what the second word needs.
  assign wide_w   = {32'h0000_0000, wdata} << shamt;
  assign wdata_lo = wide_w[31:0];
  assign wdata_hi = wide_w[63:32];

  assign raw = 32'({w1, w0} >> shamt);

  always_comb begin
    rdata = raw;
    case (size)
      SZ_BYTE: rdata = {{24{~is_unsigned & raw[7]}}, raw[7:0]};
      SZ_HALF: rdata = {{16{~is_unsigned & raw[15]}}, raw[15:0]};
      default: rdata = raw;
    endcase
  end

endmodule

// File: rtl/lsu_data.sv
// Load/store unit between the core and data memory: one request at a time,
// word-aligned memory accesses, boundary-crossing accesses split in two.
module lsu_data
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [1:0]            req_size_i,
  input  logic                  req_unsigned_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic [3:0]            mem_write_transfer_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  state_t                state, state_next;
  logic                  we_q;
  logic                  unsigned_q;
  logic [1:0]            size_q;
  logic [1:0]            off_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] lo_q;
  logic [ADDR_WIDTH-1:0] wa_q;
  logic [ADDR_WIDTH-1:0] wa1;
  logic                  accept;
  logic                  split;
  logic [3:0]            span;
  logic [7:0]            mask;
  logic [31:0]           wdata_lo;
  logic [31:0]           wdata_hi;
  logic [31:0]           w0;
  logic [31:0]           w1;
  logic [31:0]           ext;

  assign req_ready_o = rst_n && (state == IDLE);
  assign accept      = req_valid_i && req_ready_o;

  assign span  = {2'b00, off_q} + {1'b0, size_to_bytes(size_q)};
  assign split = span > 4'd4;
  assign wa1   = wa_q + ADDR_WIDTH'(4);

  // In CAPT the memory returns the last word read; for split loads that is word 1.
  assign w0 = split ? lo_q : mem_rdata_i;
  assign w1 = split ? mem_rdata_i : 32'h0000_0000;

  lsu_align u_align (
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .offset      (off_q),
    .wdata       (wdata_q),
    .w0          (w0),
    .w1          (w1),
    .mask        (mask),
    .wdata_lo    (wdata_lo),
    .wdata_hi    (wdata_hi),
    .rdata       (ext)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q       <= 1'b0;
      unsigned_q <= 1'b0;
      size_q     <= SZ_WORD;
      off_q      <= 2'b00;
      wdata_q    <= '0;
      wa_q       <= '0;
      lo_q       <= '0;
    end else begin
      if (accept) begin
        we_q       <= req_we_i;
        unsigned_q <= req_unsigned_i;
        size_q     <= req_size_i;
        off_q      <= req_addr_i[1:0];
        wdata_q    <= req_wdata_i;
        wa_q       <= {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
      end
      if (state == ACC1) begin
        lo_q <= mem_rdata_i;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ACC0;
      ACC0:    state_next = split ? ACC1 : CAPT;
      ACC1:    state_next = CAPT;
      CAPT:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_we_o             = 1'b0;
    mem_addr_o           = '0;
    mem_wdata_o          = '0;
    mem_write_transfer_o = 4'b0000;
    case (state)
      ACC0: begin
        mem_addr_o           = wa_q;
        mem_we_o             = we_q && rst_n;
        mem_wdata_o          = we_q ? wdata_lo : '0;
        mem_write_transfer_o = we_q ? mask[3:0] : 4'b0000;
      end
      ACC1: begin
        mem_addr_o           = wa1;
        mem_we_o             = we_q && rst_n;
        mem_wdata_o          = we_q ? wdata_hi : '0;
        mem_write_transfer_o = we_q ? mask[7:4] : 4'b0000;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
    end else begin
      rsp_valid_o <= (state == CAPT);
      if (state == CAPT) begin
        rsp_rdata_o <= we_q ? '0 : ext;
      end
    end
  end

endmodule
